// File: rtl/bcd_seg_display_pkg.sv
// Shared definitions for the BCD seven-segment display stage: segment patterns,
// FSM state encoding and the counter-width helper.
package display_pkg;

  // Active-low patterns, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int cnt_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bcd_seg_display_if.sv
// Value/segment bundle between the press counter and the display stage.
interface bcd_seg_display_if #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
);
    logic [WIDTH-1:0]    value;
    logic [7*DIGITS-1:0] hex;
    logic                busy;

    modport master (output value, input hex, input busy);
    modport slave  (input value, output hex, output busy);
endinterface

// File: rtl/bcd_seg_display_seg7_encode.sv
// One BCD digit to seven segments, with blanking and selectable polarity.
module seg7_encode
    import display_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    input  logic       active_low_i,
    output logic [6:0] seg_o
);
    logic [6:0] pat;

    always_comb begin
        pat = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    pat = SEG_0;
                4'd1:    pat = SEG_1;
                4'd2:    pat = SEG_2;
                4'd3:    pat = SEG_3;
                4'd4:    pat = SEG_4;
                4'd5:    pat = SEG_5;
                4'd6:    pat = SEG_6;
                4'd7:    pat = SEG_7;
                4'd8:    pat = SEG_8;
                4'd9:    pat = SEG_9;
                default: pat = SEG_BLANK;
            endcase
        end
        seg_o = active_low_i ? pat : ~pat;
    end
endmodule

// File: rtl/bcd_seg_display.sv
// Binary-to-BCD display stage: sequential double-dabble conversion whenever the
// input differs from the last converted value, then registered segment drives.
module bcd_seg_display
    import display_pkg::*;
#(
    parameter int WIDTH          = 10,
    parameter int DIGITS         = 4,
    parameter bit BLANK_LZ       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic          clock,
    input  logic          reset,
    bcd_seg_display_if.slave bus
);
    localparam int CNT_W = cnt_bits(WIDTH);
    localparam int SCR_W = 4 * DIGITS;
    localparam logic [6:0]          SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [7*DIGITS-1:0] HEX_OFF = {DIGITS{SEG_OFF}};

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    shift_q, shift_d;
    logic [WIDTH-1:0]    shown_q, shown_d;
    logic                shown_valid_q, shown_valid_d;
    logic [SCR_W-1:0]    scratch_q, scratch_d;
    logic [SCR_W-1:0]    digits_q, digits_d;
    logic [7*DIGITS-1:0] hex_q, hex_d;
    logic                busy_q, busy_d;

    logic [SCR_W-1:0]    adjusted;
    logic [DIGITS-1:0]   blank;
    logic [7*DIGITS-1:0] enc_hex;

    always_comb begin
        logic [3:0] nib;
        adjusted = '0;
        for (int k = 0; k < DIGITS; k++) begin
            nib = scratch_q[4*k +: 4];
            adjusted[4*k +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    end

    // A digit is blanked only while every digit above it is also zero
    always_comb begin
        logic lead;
        blank = '0;
        lead  = BLANK_LZ;
        for (int k = DIGITS - 1; k > 0; k--) begin
            lead     = lead && (scratch_q[4*k +: 4] == 4'd0);
            blank[k] = lead;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        seg7_encode u_enc (
            .digit_i      (scratch_q[4*g +: 4]),
            .blank_i      (blank[g]),
            .active_low_i (SEG_ACTIVE_LOW),
            .seg_o        (enc_hex[7*g +: 7])
        );
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        shown_d       = shown_q;
        shown_valid_d = shown_valid_q;
        scratch_d     = scratch_q;
        digits_d      = digits_q;
        hex_d         = hex_q;
        busy_d        = busy_q;
        case (state_q)
            IDLE: begin
                if (!shown_valid_q || (bus.value != shown_q)) begin
                    shift_d   = bus.value;
                    shown_d   = bus.value;
                    scratch_d = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // Top bit shifted out of the scratch cannot be set for legal parameters
                {scratch_d, shift_d} = {adjusted, shift_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                digits_d      = scratch_q;
                hex_d         = enc_hex;
                shown_valid_d = 1'b1;
                busy_d        = 1'b0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shift_q       <= '0;
            shown_q       <= '0;
            shown_valid_q <= 1'b0;
            scratch_q     <= '0;
            digits_q      <= '0;
            hex_q         <= HEX_OFF;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            shown_q       <= shown_d;
            shown_valid_q <= shown_valid_d;
            scratch_q     <= scratch_d;
            digits_q      <= digits_d;
            hex_q         <= hex_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.hex  = hex_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_bcd_seg_display.sv
// Scoreboard bench: three display instances (blanking/polarity variants) fed the same
// values, checked against a decimal reference model whenever a conversion completes.
module tb_bcd_seg_display;
    localparam int WIDTH  = 10;
    localparam int DIGITS = 4;
    localparam int HW     = 7 * DIGITS;

    localparam logic [6:0] PAT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef struct {
        int            v;
        logic [HW-1:0] ha;
        logic [HW-1:0] hb;
        logic [HW-1:0] hc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    bcd_seg_display_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus_a ();
    bcd_seg_display_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus_b ();
    bcd_seg_display_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus_c ();

    bcd_seg_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1))
        dut_a (.clock(clock), .reset(reset), .bus(bus_a.slave));
    bcd_seg_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b1))
        dut_b (.clock(clock), .reset(reset), .bus(bus_b.slave));
    bcd_seg_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b0))
        dut_c (.clock(clock), .reset(reset), .bus(bus_c.slave));

    int   n_total = 0;
    int   n_pass  = 0;
    exp_t expq[$];

    function automatic logic [HW-1:0] model_hex(input int v, input bit blz, input bit alow);
        logic [HW-1:0] h;
        logic [6:0]    pat;
        int            p;
        p = 1;
        h = '0;
        for (int k = 0; k < DIGITS; k++) begin
            pat = (blz && k > 0 && v < p) ? 7'h7F : PAT[(v / p) % 10];
            h[7*k +: 7] = alow ? pat : ~pat;
            p = p * 10;
        end
        return h;
    endfunction

    function automatic logic [HW-1:0] model_off(input bit alow);
        return alow ? {HW{1'b1}} : {HW{1'b0}};
    endfunction

    task automatic check(input string name, input logic [HW-1:0] act, input logic [HW-1:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    endtask

    task automatic set_value(input int v, input bit push);
        exp_t e;
        bus_a.value = WIDTH'(v);
        bus_b.value = WIDTH'(v);
        bus_c.value = WIDTH'(v);
        if (push) begin
            e.v  = v;
            e.ha = model_hex(v, 1'b1, 1'b1);
            e.hb = model_hex(v, 1'b0, 1'b1);
            e.hc = model_hex(v, 1'b1, 1'b0);
            expq.push_back(e);
        end
    endtask

    task automatic wait_done();
        bit seen;
        bit done;
        seen = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clock);
            if (bus_a.busy) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        if (!done) begin
            n_total++;
            $display("FAIL wait_done: conversion did not finish within 60 cycles (t=%0t)", $time);
        end
    endtask

    // Monitor: on each completed conversion pop and compare; otherwise hex must hold
    bit            prev_busy = 1'b0;
    int            busy_cnt  = 0;
    logic [HW-1:0] last_a, last_b, last_c;
    always @(negedge clock) begin
        if (!reset) begin
            prev_busy = 1'b0;
            busy_cnt  = 0;
            last_a    = model_off(1'b1);
            last_b    = model_off(1'b1);
            last_c    = model_off(1'b0);
        end else begin
            if (bus_a.busy) busy_cnt++;
            if (prev_busy && !bus_a.busy) begin
                check("busy_len", HW'(busy_cnt), HW'(WIDTH + 1));
                busy_cnt = 0;
                if (expq.size() == 0) begin
                    n_total++;
                    $display("FAIL scoreboard: conversion finished with no expectation queued, hex=%h", bus_a.hex);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check($sformatf("hex_a v=%0d", e.v), bus_a.hex, e.ha);
                    check($sformatf("hex_b v=%0d", e.v), bus_b.hex, e.hb);
                    check($sformatf("hex_c v=%0d", e.v), bus_c.hex, e.hc);
                    last_a = e.ha;
                    last_b = e.hb;
                    last_c = e.hc;
                end
            end else begin
                check("hold_a", bus_a.hex, last_a);
                check("hold_b", bus_b.hex, last_b);
                check("hold_c", bus_c.hex, last_c);
            end
            prev_busy = bus_a.busy;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v, prev;
        set_value(0, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_hex_a", bus_a.hex, model_off(1'b1));
        check("rst_hex_c", bus_c.hex, model_off(1'b0));
        check("rst_busy", HW'(bus_a.busy), HW'(0));

        // First conversion is forced out of reset even though value is 0
        set_value(0, 1'b1);
        reset = 1'b1;
        wait_done();

        set_value(1023, 1'b1);
        wait_done();
        check("lit_1023", bus_a.hex, {7'b1111001, 7'b1000000, 7'b0100100, 7'b0110000});

        set_value(100, 1'b1);
        wait_done();
        check("lit_100_blank", bus_a.hex, {7'b1111111, 7'b1111001, 7'b1000000, 7'b1000000});
        check("lit_100_noblank", bus_b.hex, {7'b1000000, 7'b1111001, 7'b1000000, 7'b1000000});

        // Value changes mid-conversion: 5 completes first, then 6 is picked up
        set_value(5, 1'b1);
        repeat (3) @(negedge clock);
        set_value(6, 1'b1);
        wait_done();
        check("lit_5", bus_a.hex[6:0], 7'b0010010);
        @(negedge clock);
        check("busy_reassert", HW'(bus_a.busy), HW'(1));
        wait_done();
        check("lit_6", bus_a.hex[6:0], 7'b0000010);

        for (int i = 0; i < 1024; i++) begin
            set_value(i, 1'b1);
            wait_done();
        end

        prev = 1023;
        for (int i = 0; i < 40; i++) begin
            do v = int'($urandom_range(0, 1023)); while (v == prev);
            set_value(v, 1'b1);
            wait_done();
            prev = v;
        end

        // Reset mid-conversion of 999: nothing partial is committed
        set_value(999, 1'b0);
        repeat (6) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("abort_hex_a", bus_a.hex, model_off(1'b1));
        check("abort_hex_c", bus_c.hex, model_off(1'b0));
        check("abort_busy", HW'(bus_a.busy), HW'(0));
        set_value(999, 1'b1);
        reset = 1'b1;
        wait_done();
        check("lit_999", bus_a.hex, {7'b1111111, 7'b0010000, 7'b0010000, 7'b0010000});

        repeat (3) @(negedge clock);
        n_total++;
        if (expq.size() == 0) n_pass++;
        else $display("FAIL leftover: %0d expectations never matched, required 0", expq.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/bcd_seg_display.md
Name: bcd_seg_display

Overview:
Downstream display stage for the 10-bit LED press counter.
- Takes the counter's binary value and converts it to decimal BCD with a sequential double-dabble (shift-add-3) engine.
- Drives four seven-segment digits on the board, with optional leading-zero blanking.
- Re-converts automatically whenever the input value differs from the last value it converted.

Parameters:
WIDTH, 10, bit width of binary input; conversion takes WIDTH shift cycles
DIGITS, 4, number of BCD digits/displays; must satisfy 10^DIGITS > 2^WIDTH-1
BLANK_LZ, 1, 1 = leading zero digits blanked (digit 0 always shown); 0 = all digits shown
SEG_ACTIVE_LOW, 1, 1 = segment on drives 0 (board default); 0 = inverted polarity

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low reset
value  input  WIDTH  binary value to display (from counter, already synchronous to clock)
hex    output  7*DIGITS  segment drives, digit k at [7k+6:7k], bit0=a … bit6=g
busy   output  1  high while a conversion is in progress

Behaviour:
- Reset is synchronous and active-low, clocked by clock.
- Reset (reset==0 at posedge):
  - FSM goes to IDLE; BCD result registers clear to 0; busy=0.
  - hex = all segments off (7'h7F per digit when SEG_ACTIVE_LOW).
  - The internal "shown_valid" flag clears, forcing a conversion on the first cycle out of reset.
- FSM states:
  - IDLE: if (!shown_valid || value != shown_value), capture value into shift register and shown_value, clear BCD scratch, set cnt=0, go to SHIFT, busy=1. Otherwise stay.
  - SHIFT: per cycle, add 3 to each scratch nibble >=5, then shift {scratch, shiftreg} left by 1. cnt increments; after WIDTH cycles (cnt==WIDTH-1) go to DONE.
  - DONE: copy scratch to result digits, recompute hex, set shown_valid=1, busy=0, go to IDLE.
- Latency: value sampled at edge N (IDLE). hex reflects it from edge N+WIDTH+1, i.e. 12 clocks for WIDTH=10.
- Value changes during SHIFT/DONE are ignored by the engine. The IDLE compare picks them up on the next cycle, so the final settled value is always displayed. hex never shows a partial result.
- Add-3 is applied to all DIGITS nibbles before each shift. Scratch width is 4*DIGITS; the shift-out of the top nibble is discarded, which cannot overflow given the parameter constraint.
- Blanking (BLANK_LZ=1):
  - Digit k>0 is blanked iff it and all higher digits are 0.
  - Digit 0 is never blanked; value 0 shows "0".
  - Interior zeros are shown.
- Digit encoding, active-low, gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
  - Nibble values 10-15 are unreachable; encode as blank.
  - SEG_ACTIVE_LOW=0 inverts all patterns.
- Reset mid-conversion aborts immediately to the reset state; no partial result is committed.
- hex and busy are registered outputs; there is no combinational path from value to hex.

Decomposition:
- Shared package (display_pkg):
  - seven-segment pattern constants SEG_0..SEG_9, SEG_BLANK
  - FSM state encoding IDLE/SHIFT/DONE
  - a counter-width helper constant
- One sub-module, seg7_encode (4-bit digit + blank flag + polarity -> 7 segments, combinational), instantiated DIGITS times. Its outputs are registered in the parent.

Test Plan:
- Release reset with value=0 -> busy high for 11 cycles; 12 clocks later hex0=1000000, hex1..hex3=1111111, busy=0.
- value=1023 -> after 12 clocks hex3=1111001, hex2=1000000, hex1=0100100, hex0=0110000 (1023).
- value=100 with BLANK_LZ=1 -> hex3 blank, hex2=1111001, hex1=1000000, hex0=1000000. Rerun with BLANK_LZ=0 -> hex3=1000000.
- value 5 -> 6 changed at SHIFT cycle 3 -> hex first shows 5 (0010010), busy reasserts the next cycle after DONE, then shows 6 (0000010). No intermediate garbage appears on hex.
- Stepping value 0..1023 by +1, each held until busy falls -> every decoded digit tuple equals the decimal value (scoreboard compare).
- reset asserted at SHIFT cycle 5 while converting 999 -> hex all 1111111 and busy=0 on the next edge. After release, a fresh conversion completes and shows 999.
